// File: rtl/axi_wr_arbiter.sv
// Two-requester AXI write arbiter (0=DMA, 1=CPU), one burst in flight.
// Round-robin grant, beat-counted m_wlast, sticky wlast mismatch flag.
module axi_wr_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s0_awaddr,
  input  logic [7:0]        s0_awlen,
  input  logic [1:0]        s0_awburst,
  input  logic              s0_awvalid,
  output logic              s0_awready,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic              s0_wlast,
  input  logic              s0_wvalid,
  output logic              s0_wready,
  output logic [1:0]        s0_bresp,
  output logic              s0_bvalid,
  input  logic              s0_bready,
  input  logic [ADDR_W-1:0] s1_awaddr,
  input  logic [7:0]        s1_awlen,
  input  logic [1:0]        s1_awburst,
  input  logic              s1_awvalid,
  output logic              s1_awready,
  input  logic [DATA_W-1:0] s1_wdata,
  input  logic              s1_wlast,
  input  logic              s1_wvalid,
  output logic              s1_wready,
  output logic [1:0]        s1_bresp,
  output logic              s1_bvalid,
  input  logic              s1_bready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [7:0]        m_awlen,
  output logic [1:0]        m_awburst,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [1:0]        grant,
  output logic              wlast_err
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  state_t     state;
  logic       ptr;
  logic [7:0] cnt;
  logic [7:0] len;

  logic sel;
  logic in_addr;
  logic in_data;
  logic in_resp;
  logic last_beat;
  logic s_wlast;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic pick1;

  assign sel = grant[1];

  // Gating with reset keeps every handshake output low while reset is held.
  assign in_addr = !reset && state == ADDR;
  assign in_data = !reset && state == DATA;
  assign in_resp = !reset && state == RESP;

  assign last_beat = cnt == len;
  assign s_wlast   = sel ? s1_wlast : s0_wlast;
  assign aw_hs     = m_awvalid && m_awready;
  assign w_hs      = m_wvalid && m_wready;
  assign b_hs      = m_bvalid && m_bready;
  assign pick1     = s1_awvalid && (!s0_awvalid || ptr);

  always_comb begin
    m_awaddr   = sel ? s1_awaddr : s0_awaddr;
    m_awlen    = sel ? s1_awlen : s0_awlen;
    m_awburst  = sel ? s1_awburst : s0_awburst;
    m_awvalid  = in_addr && (sel ? s1_awvalid : s0_awvalid);
    s0_awready = in_addr && !sel && m_awready;
    s1_awready = in_addr && sel && m_awready;
    m_wdata    = sel ? s1_wdata : s0_wdata;
    m_wvalid   = in_data && (sel ? s1_wvalid : s0_wvalid);
    m_wlast    = in_data && last_beat;
    s0_wready  = in_data && !sel && m_wready;
    s1_wready  = in_data && sel && m_wready;
    m_bready   = in_resp && (sel ? s1_bready : s0_bready);
    s0_bvalid  = in_resp && !sel && m_bvalid;
    s1_bvalid  = in_resp && sel && m_bvalid;
    s0_bresp   = m_bresp;
    s1_bresp   = m_bresp;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 2'b00;
      ptr       <= 1'b0;
      cnt       <= 8'd0;
      len       <= 8'd0;
      wlast_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (s0_awvalid || s1_awvalid) begin
            grant <= pick1 ? 2'b10 : 2'b01;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (aw_hs) begin
            len   <= m_awlen;
            cnt   <= 8'd0;
            state <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            if (s_wlast != last_beat)
              wlast_err <= 1'b1;
            if (last_beat)
              state <= RESP;
            else
              cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          if (b_hs) begin
            state <= IDLE;
            grant <= 2'b00;
            ptr   <= !sel;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, AXI address width.
REQ-002 Parameter DATA_W, default 64, AXI write-data width.
REQ-003 Port clk  in  1  single clock (125 MHz AXI domain); all logic is synchronous to it.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Ports sN_awaddr/sN_awlen/sN_awburst/sN_awvalid  in  ADDR_W/8/2/1  write-address channel from requester N. Requester 0 is the DMA, requester 1 is the CPU.
REQ-006 Port sN_awready  out  1  address accept to requester N.
REQ-007 Ports sN_wdata/sN_wlast/sN_wvalid  in  DATA_W/1/1  write-data channel from requester N.
REQ-008 Port sN_wready  out  1  data accept to requester N.
REQ-009 Ports sN_bresp/sN_bvalid  out  2/1  write response to requester N.
REQ-010 Port sN_bready  in  1  response accept from requester N.
REQ-011 Ports m_awaddr/m_awlen/m_awburst/m_awvalid  out  ADDR_W/8/2/1  shared downstream AW channel.
REQ-012 Port m_awready  in  1  downstream AW accept.
REQ-013 Ports m_wdata/m_wlast/m_wvalid  out  DATA_W/1/1  shared downstream W channel.
REQ-014 Port m_wready  in  1  downstream W accept.
REQ-015 Ports m_bresp/m_bvalid  in  2/1; port m_bready  out  1  shared downstream B channel.
REQ-016 Port grant  out  2  one-hot current owner (bit N = requester N); 00 when idle.
REQ-017 Port wlast_err  out  1  sticky flag: requester wlast disagreed with its awlen.

Function
REQ-018 FSM states: IDLE, ADDR, DATA, RESP. Exactly one transaction (AW, all W beats, B) is in flight at a time.
REQ-019 In IDLE with any sN_awvalid high, the FSM registers a one-hot grant and enters ADDR on the next edge. m_awvalid rises one cycle after the request is sampled.
REQ-020 Round-robin: a 1-bit priority pointer names the preferred requester. If both request, the preferred one wins. The pointer moves to the other requester when a B handshake completes.
REQ-021 In ADDR, the granted requester's AW fields and valid pass combinationally to m_aw*. m_awready returns only to the granted sN_awready. Non-granted awready stays 0.
REQ-022 On the AW handshake, awlen is latched, the beat counter clears to 0, and the FSM enters DATA.
REQ-023 In DATA, the granted W channel is muxed to m_w*, and m_wready returns only to the granted sN_wready. m_wlast is driven high when beat counter == latched awlen, not from sN_wlast. The counter increments on each m_wvalid&m_wready.
REQ-024 On a W handshake where sN_wlast != (counter==awlen), set wlast_err. The handshake completes normally.
REQ-025 On the handshake of the final beat, enter RESP. sN_wready is 0 outside DATA.
REQ-026 In RESP, m_bresp/m_bvalid route to the granted requester. m_bready = granted sN_bready. Non-granted sN_bvalid = 0.
REQ-027 On the B handshake, return to IDLE and clear grant. A new grant can be issued one cycle later, so there is a 1-cycle minimum bubble between transactions.
REQ-028 Requests arriving while busy wait; valid is held by the requester. Requests are never dropped or reordered per requester.
REQ-029 awlen=0 is a single beat: m_wlast=1 on the first beat. awlen=255 is 256 beats; the counter is 8 bits and never wraps within a burst.
REQ-030 Downstream stalls (m_awready/m_wready/m_bready low) hold the state indefinitely. No timeout.

Reset
REQ-031 While reset=1, asynchronously force: state IDLE, grant=00, priority pointer=0 (DMA preferred), counter=0, wlast_err=0.
REQ-032 While reset=1, asynchronously force all ready/valid outputs (sN_awready, sN_wready, sN_bvalid, m_awvalid, m_wvalid, m_bready) to 0. Reset during a burst abandons it with no further handshakes.

Verification
REQ-033 Both sN_awvalid rise in the same cycle after reset -> grant=01; the DMA burst completes; grant=00 for 1 cycle; then grant=10 for the CPU.
REQ-034 DMA awlen=3, m_wready toggling 1/0 -> exactly 4 W handshakes downstream; m_wlast only on the 4th; then one B routed to s0 only.
REQ-035 CPU awlen=0 with s1_wlast=0 -> m_wlast=1 on the single beat; wlast_err=1 and stays 1 until reset.
REQ-036 DMA streams back-to-back while the CPU requests continuously -> grants alternate 01,10,01,10; neither side gets two consecutive grants.
REQ-037 reset asserted in DATA after 2 of 8 beats -> all valid/ready outputs 0 in the same cycle; after release, grant=00, wlast_err=0, and a new DMA request is serviced from beat 0.
